mem_access: RTL and testbench

- MEM-stage controller of the 5-stage MIPS32 pipeline; consumes the registered outputs of the EX/MEM pipeline register.
- Performs LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus and stalls the pipeline while the bus is busy.
- Registers the write-back triple (wReg/wAddr/wData) toward the register-file write port.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access -- MEM-stage controller for the 5-stage MIPS32 pipeline.
//
// Takes the registered EX/MEM outputs and does one of three things:
//  - passes ALU results through to write-back with one cycle of latency,
//  - flags misaligned halfword/word accesses without touching the bus,
//  - runs a byte/halfword/word load or store on the req/ack data bus and
//    holds the upstream pipeline (stall_req) until the transfer completes
//    or times out.
//
// Ports:
//   clk, rst                          clock; synchronous active-high reset
//   mem_wReg/wAddr/wData              write-back triple from EX/MEM
//   mem_op                            0=ALU, 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW
//   mem_addr, mem_sdata               effective address, store data
//   dbus_req/we/addr/sel/wdata        registered bus request (big-endian lanes)
//   dbus_rdata, dbus_ack              bus read data and completion
//   stall_req                         combinational pipeline hold
//   wb_wReg/wAddr/wData               registered write-back toward the register file
//   exc_misalign, bus_err             single-cycle registered fault pulses
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wReg,
  input  logic [4:0]  mem_wAddr,
  input  logic [31:0] mem_wData,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        stall_req,
  output logic        wb_wReg,
  output logic [4:0]  wb_wAddr,
  output logic [31:0] wb_wData,
  output logic        exc_misalign,
  output logic        bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbus_req_q, dbus_req_d;
  logic             dbus_we_q, dbus_we_d;
  logic [31:0]      dbus_addr_q, dbus_addr_d;
  logic [3:0]       dbus_sel_q, dbus_sel_d;
  logic [31:0]      dbus_wdata_q, dbus_wdata_d;
  logic             wb_wReg_q, wb_wReg_d;
  logic [4:0]       wb_wAddr_q, wb_wAddr_d;
  logic [31:0]      wb_wData_q, wb_wData_d;
  logic             exc_misalign_q, exc_misalign_d;
  logic             bus_err_q, bus_err_d;

  // Operation decode
  logic is_load, is_store, is_mem, sz_byte, sz_half, sz_word, misaligned;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;

  always_comb begin
    is_load  = (mem_op >= 4'd1) && (mem_op <= 4'd5);
    is_store = (mem_op >= 4'd6) && (mem_op <= 4'd8);
    is_mem   = is_load || is_store;
    sz_byte  = (mem_op == 4'd1) || (mem_op == 4'd2) || (mem_op == 4'd6);
    sz_half  = (mem_op == 4'd3) || (mem_op == 4'd4) || (mem_op == 4'd7);
    sz_word  = (mem_op == 4'd5) || (mem_op == 4'd8);
    misaligned = (sz_half && mem_addr[0]) || (sz_word && (mem_addr[1:0] != 2'b00));

    // Big-endian lanes: address offset 00 lives in bits 31:24 (sel[3]).
    lane_sel   = 4'b1111;
    lane_wdata = mem_sdata;
    if (sz_byte) begin
      lane_sel   = 4'b1000 >> mem_addr[1:0];
      lane_wdata = {4{mem_sdata[7:0]}};
    end else if (sz_half) begin
      lane_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
      lane_wdata = {2{mem_sdata[15:0]}};
    end
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [3:0]  op,
                                              input logic [1:0]  a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[31:24];
    case (a)
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      2'b11:   b = rd[7:0];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[15:0] : rd[31:16];
    case (op)
      4'd1:    r = {{24{b[7]}}, b};
      4'd2:    r = {24'h0, b};
      4'd3:    r = {{16{h[15]}}, h};
      4'd4:    r = {16'h0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dbus_req_d     = dbus_req_q;
    dbus_we_d      = dbus_we_q;
    dbus_addr_d    = dbus_addr_q;
    dbus_sel_d     = dbus_sel_q;
    dbus_wdata_d   = dbus_wdata_q;
    wb_wReg_d      = 1'b0;
    wb_wAddr_d     = wb_wAddr_q;
    wb_wData_d     = wb_wData_q;
    exc_misalign_d = 1'b0;
    bus_err_d      = 1'b0;
    stall_req      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!is_mem) begin
          wb_wReg_d  = mem_wReg;
          wb_wAddr_d = mem_wAddr;
          wb_wData_d = mem_wData;
        end else if (misaligned) begin
          exc_misalign_d = 1'b1;
        end else begin
          stall_req    = 1'b1;
          dbus_req_d   = 1'b1;
          dbus_we_d    = is_store;
          dbus_addr_d  = {mem_addr[31:2], 2'b00};
          dbus_sel_d   = lane_sel;
          dbus_wdata_d = lane_wdata;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dbus_ack) begin
          dbus_req_d = 1'b0;
          state_d    = S_IDLE;
          if (is_load) begin
            wb_wReg_d  = 1'b1;
            wb_wAddr_d = mem_wAddr;
            wb_wData_d = load_extend(mem_op, mem_addr[1:0], dbus_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort: release the pipeline this cycle so it never sees a stale hold.
          dbus_req_d = 1'b0;
          bus_err_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stall_req = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dbus_req_q     <= 1'b0;
      dbus_we_q      <= 1'b0;
      dbus_addr_q    <= '0;
      dbus_sel_q     <= '0;
      dbus_wdata_q   <= '0;
      wb_wReg_q      <= 1'b0;
      wb_wAddr_q     <= '0;
      wb_wData_q     <= '0;
      exc_misalign_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dbus_req_q     <= dbus_req_d;
      dbus_we_q      <= dbus_we_d;
      dbus_addr_q    <= dbus_addr_d;
      dbus_sel_q     <= dbus_sel_d;
      dbus_wdata_q   <= dbus_wdata_d;
      wb_wReg_q      <= wb_wReg_d;
      wb_wAddr_q     <= wb_wAddr_d;
      wb_wData_q     <= wb_wData_d;
      exc_misalign_q <= exc_misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign dbus_req     = dbus_req_q;
  assign dbus_we      = dbus_we_q;
  assign dbus_addr    = dbus_addr_q;
  assign dbus_sel     = dbus_sel_q;
  assign dbus_wdata   = dbus_wdata_q;
  assign wb_wReg      = wb_wReg_q;
  assign wb_wAddr     = wb_wAddr_q;
  assign wb_wData     = wb_wData_q;
  assign exc_misalign = exc_misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- directed, table-driven bench for mem_access.
// A vector table covers ALU pass-through, every load/store width, lane
// selection, sign/zero extension and misalignment; hand-written sequences
// cover bus timeout and reset during a pending transfer.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wReg;
  logic [4:0]  mem_wAddr;
  logic [31:0] mem_wData;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        stall_req;
  logic        wb_wReg;
  logic [4:0]  wb_wAddr;
  logic [31:0] wb_wData;
  logic        exc_misalign;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_wReg(mem_wReg), .mem_wAddr(mem_wAddr), .mem_wData(mem_wData),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .stall_req(stall_req),
    .wb_wReg(wb_wReg), .wb_wAddr(wb_wAddr), .wb_wData(wb_wData),
    .exc_misalign(exc_misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          nwait;   // WAIT cycles without ack before the ack cycle
    int          e_stall; // cycles stall_req is high (0 = no bus cycle)
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_wd;
    logic        e_wreg;
    logic [31:0] e_data;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mem_op = 4'd0; mem_wReg = 1'b0; mem_wAddr = 5'd0; mem_wData = 32'h0;
    mem_addr = 32'h0; mem_sdata = 32'h0;
  endtask

  // Entered and left at posedge+1.
  task automatic run_vec(input vec_t v);
    int stalls;
    mem_op = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
    mem_wReg = v.wreg; mem_wAddr = v.waddr; mem_wData = v.wdata;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    #1;
    stalls = int'(stall_req);
    if (v.e_stall == 0) begin
      @(posedge clk); #1;
      chk("nobus_stall", stalls, 0);
      chk("nobus_req", dbus_req, 0);
      chk("nobus_wb_wReg", wb_wReg, v.e_wreg);
      if (v.e_wreg) begin
        chk("nobus_wb_wAddr", wb_wAddr, v.waddr);
        chk("nobus_wb_wData", wb_wData, v.e_data);
      end
      chk("nobus_misalign", exc_misalign, v.mis);
      idle_inputs();
      @(posedge clk); #1;
      chk("misalign_clear", exc_misalign, 0);
    end else begin
      @(posedge clk); #1;
      chk("issue_req", dbus_req, 1);
      chk("issue_addr", dbus_addr, v.e_addr);
      chk("issue_sel", dbus_sel, v.e_sel);
      chk("issue_we", dbus_we, v.e_we);
      if (v.e_we) chk("issue_wdata", dbus_wdata, v.e_wd);
      chk("issue_bubble", wb_wReg, 0);
      for (int k = 0; k < v.nwait; k++) begin
        #1 stalls += int'(stall_req);
        @(posedge clk); #1;
        chk("wait_req_held", dbus_req, 1);
      end
      dbus_ack = 1'b1; dbus_rdata = v.rdata;
      #1 stalls += int'(stall_req);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      idle_inputs();
      chk("done_req", dbus_req, 0);
      chk("done_wb_wReg", wb_wReg, v.e_wreg);
      if (v.e_wreg) begin
        chk("done_wb_wAddr", wb_wAddr, v.waddr);
        chk("done_wb_wData", wb_wData, v.e_data);
      end
      chk("stall_cycles", stalls, v.e_stall);
    end
  endtask

  initial begin
    int n;
    logic last_stall;

    //        op  addr        sdata         rdata         wr wa     wdata        nw st e_addr       sel      we e_wd          ewr e_data       mis
    vecs[0]  = '{4'd0,  32'h0,   32'h0,        32'h0,        1, 5'd5,  32'h12345678, 0, 0, 32'h0,   4'b0000, 0, 32'h0,        1, 32'h12345678, 0};
    vecs[1]  = '{4'd12, 32'h40,  32'h0,        32'h0,        1, 5'd7,  32'hCAFEF00D, 0, 0, 32'h0,   4'b0000, 0, 32'h0,        1, 32'hCAFEF00D, 0};
    vecs[2]  = '{4'd1,  32'h103, 32'h0,        32'hAABBCC80, 1, 5'd9,  32'h0,        1, 2, 32'h100, 4'b0001, 0, 32'h0,        1, 32'hFFFFFF80, 0};
    vecs[3]  = '{4'd2,  32'h103, 32'h0,        32'hAABBCC80, 1, 5'd10, 32'h0,        0, 1, 32'h100, 4'b0001, 0, 32'h0,        1, 32'h00000080, 0};
    vecs[4]  = '{4'd7,  32'h202, 32'h0000BEEF, 32'h0,        0, 5'd0,  32'h0,        3, 4, 32'h200, 4'b0011, 1, 32'hBEEFBEEF, 0, 32'h0,        0};
    vecs[5]  = '{4'd5,  32'h301, 32'h0,        32'h0,        1, 5'd3,  32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        0, 32'h0,        1};
    vecs[6]  = '{4'd3,  32'h200, 32'h0,        32'h80011234, 1, 5'd11, 32'h0,        2, 3, 32'h200, 4'b1100, 0, 32'h0,        1, 32'hFFFF8001, 0};
    vecs[7]  = '{4'd4,  32'h206, 32'h0,        32'h1234F00D, 1, 5'd12, 32'h0,        0, 1, 32'h204, 4'b0011, 0, 32'h0,        1, 32'h0000F00D, 0};
    vecs[8]  = '{4'd6,  32'h401, 32'h123456A5, 32'h0,        0, 5'd0,  32'h0,        1, 2, 32'h400, 4'b0100, 1, 32'hA5A5A5A5, 0, 32'h0,        0};
    vecs[9]  = '{4'd8,  32'h500, 32'hDEADBEEF, 32'h0,        0, 5'd0,  32'h0,        0, 1, 32'h500, 4'b1111, 1, 32'hDEADBEEF, 0, 32'h0,        0};
    vecs[10] = '{4'd5,  32'h604, 32'h0,        32'h01020304, 1, 5'd13, 32'h0,        0, 1, 32'h604, 4'b1111, 0, 32'h0,        1, 32'h01020304, 0};
    vecs[11] = '{4'd7,  32'h203, 32'h0,        32'h0,        0, 5'd0,  32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        0, 32'h0,        1};
    vecs[12] = '{4'd1,  32'h100, 32'h0,        32'h7F000000, 1, 5'd14, 32'h0,        0, 1, 32'h100, 4'b1000, 0, 32'h0,        1, 32'h0000007F, 0};
    vecs[13] = '{4'd3,  32'h101, 32'h0,        32'h0,        1, 5'd15, 32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        0, 32'h0,        1};

    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_sel", dbus_sel, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_wb_wReg", wb_wReg, 0);
    chk("rst_wb_wAddr", wb_wAddr, 0);
    chk("rst_wb_wData", wb_wData, 0);
    chk("rst_misalign", exc_misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Timeout: LW with no ack ever.
    mem_op = 4'd5; mem_addr = 32'h400; mem_wReg = 1'b1; mem_wAddr = 5'd20;
    #1 chk("to_issue_stall", stall_req, 1);
    @(posedge clk); #1;
    n = 0; last_stall = 1'b1;
    while (dbus_req && n < 40) begin
      #1 last_stall = stall_req;
      chk("to_no_err_early", bus_err, 0);
      n++;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("to_req_cycles", n, 16);
    chk("to_abort_stall", last_stall, 0);
    chk("to_bus_err", bus_err, 1);
    chk("to_wb_wReg", wb_wReg, 0);
    @(posedge clk); #1;
    chk("to_bus_err_clear", bus_err, 0);
    chk("to_req_idle", dbus_req, 0);

    // Reset during the 2nd WAIT cycle of an LH, then a late ack.
    mem_op = 4'd3; mem_addr = 32'h502; mem_wReg = 1'b1; mem_wAddr = 5'd21;
    @(posedge clk); #1;
    chk("rw_req", dbus_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rw_req_drop", dbus_req, 0);
    chk("rw_sel", dbus_sel, 0);
    chk("rw_addr", dbus_addr, 0);
    chk("rw_wb_wReg", wb_wReg, 0);
    chk("rw_wb_wAddr", wb_wAddr, 0);
    chk("rw_wb_wData", wb_wData, 0);
    rst = 1'b0;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    #1 chk("rw_late_ack_stall", stall_req, 0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    chk("rw_late_ack_req", dbus_req, 0);
    chk("rw_late_ack_wb", wb_wReg, 0);
    chk("rw_late_ack_data", wb_wData, 0);
    chk("rw_late_ack_err", bus_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
